// File: rtl/bitserial_nn_sequencer.sv
// bitserial_nn_sequencer: command FSM that streams weights into the bit-serial NN core and sequences per-vector compute runs.
module bitserial_nn_sequencer #(
  parameter int DATA_W   = 16,
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64,
  parameter int FRAME_W  = 8,
  localparam int HW = $clog2(N_HIDDEN > 2 ? N_HIDDEN : 2),
  localparam int IW = $clog2(N_IN > 2 ? N_IN : 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [FRAME_W-1:0] cmd_frames,
  input  logic [DATA_W-1:0]  wld_data,
  input  logic               wld_valid,
  output logic               wld_ready,
  output logic               w_wr_en,
  output logic [HW-1:0]      w_addr_h,
  output logic [IW-1:0]      w_addr_i,
  output logic [DATA_W-1:0]  w_data,
  output logic               nn_start,
  input  logic               nn_busy,
  input  logic               nn_out_valid,
  output logic               frame_done,
  output logic               run_done,
  output logic               err,
  output logic [2:0]         state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, RUN = 3'd3} state_e;
  state_e              state_q;
  logic                cmd_ready_q, wld_ready_q, w_wr_en_q, nn_start_q, frame_done_q, run_done_q, err_q;
  logic [HW-1:0]       h_q, w_addr_h_q, out_q;
  logic [IW-1:0]       i_q, w_addr_i_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [FRAME_W-1:0]  frames_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      wld_ready_q  <= 1'b0;
      w_wr_en_q    <= 1'b0;
      w_addr_h_q   <= '0;
      w_addr_i_q   <= '0;
      w_data_q     <= '0;
      nn_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      run_done_q   <= 1'b0;
      err_q        <= 1'b0;
      h_q          <= '0;
      i_q          <= '0;
      out_q        <= '0;
      frames_q     <= '0;
    end else begin
      w_wr_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      run_done_q   <= 1'b0;
      if ((wld_valid && state_q != LOAD) || (nn_out_valid && state_q != RUN))
        err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q)
            case (cmd_op)
              2'd0: begin
                state_q     <= LOAD;
                cmd_ready_q <= 1'b0;
                wld_ready_q <= 1'b1;
              end
              2'd1:
                if (cmd_frames != '0) begin
                  state_q     <= START;
                  cmd_ready_q <= 1'b0;
                  nn_start_q  <= 1'b1;
                  frames_q    <= cmd_frames;
                end else
                  run_done_q <= 1'b1;
              2'd3: err_q <= 1'b1;
              default: ;
            endcase
        end
        LOAD:
          if (wld_valid) begin
            w_wr_en_q  <= 1'b1;
            w_data_q   <= wld_data;
            w_addr_h_q <= h_q;
            w_addr_i_q <= i_q;
            if (i_q == IW'(N_IN - 1)) begin
              i_q <= '0;
              if (h_q == HW'(N_HIDDEN - 1)) begin
                h_q         <= '0;
                state_q     <= IDLE;
                wld_ready_q <= 1'b0;
                cmd_ready_q <= 1'b1;
                run_done_q  <= 1'b1;
              end else
                h_q <= h_q + 1'b1;
            end else
              i_q <= i_q + 1'b1;
          end
        // start stays high until the core reports busy; it gates start internally
        START:
          if (nn_busy) begin
            nn_start_q <= 1'b0;
            state_q    <= RUN;
          end
        // busy falling is ignored here: ReLU outputs trail the MAC phase
        RUN:
          if (nn_out_valid) begin
            if (out_q == HW'(N_HIDDEN - 1)) begin
              out_q        <= '0;
              frame_done_q <= 1'b1;
              frames_q     <= frames_q - 1'b1;
              if (frames_q == FRAME_W'(1)) begin
                state_q     <= IDLE;
                cmd_ready_q <= 1'b1;
                run_done_q  <= 1'b1;
              end else begin
                state_q    <= START;
                nn_start_q <= 1'b1;
              end
            end else
              out_q <= out_q + 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready  = cmd_ready_q;
  assign wld_ready  = wld_ready_q;
  assign w_wr_en    = w_wr_en_q;
  assign w_addr_h   = w_addr_h_q;
  assign w_addr_i   = w_addr_i_q;
  assign w_data     = w_data_q;
  assign nn_start   = nn_start_q;
  assign frame_done = frame_done_q;
  assign run_done   = run_done_q;
  assign err        = err_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_bitserial_nn_sequencer.sv
// tb_bitserial_nn_sequencer: scoreboard bench; stimulus pushes expected write/pulse events, a negedge monitor pops and compares.
module tb_bitserial_nn_sequencer;
  localparam int NI = 4;
  localparam int NH = 2;
  typedef struct packed {
    logic        wr;
    logic [0:0]  h;
    logic [1:0]  i;
    logic [15:0] d;
    logic        fd;
    logic        rd;
  } ev_t;
  logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, wld_valid = 1'b0, nn_busy = 1'b0, nn_out_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_frames = '0;
  logic [15:0] wld_data = '0;
  logic        cmd_ready, wld_ready, w_wr_en, nn_start, frame_done, run_done, err;
  logic [0:0]  w_addr_h;
  logic [1:0]  w_addr_i;
  logic [15:0] w_data;
  logic [2:0]  state_o;
  logic [28:0] outs;
  ev_t         exp_q[$];
  ev_t         act;
  int          checks = 0, errors = 0;
  bitserial_nn_sequencer #(.DATA_W(16), .N_IN(NI), .N_HIDDEN(NH), .FRAME_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_frames(cmd_frames), .wld_data(wld_data), .wld_valid(wld_valid), .wld_ready(wld_ready),
    .w_wr_en(w_wr_en), .w_addr_h(w_addr_h), .w_addr_i(w_addr_i), .w_data(w_data),
    .nn_start(nn_start), .nn_busy(nn_busy), .nn_out_valid(nn_out_valid),
    .frame_done(frame_done), .run_done(run_done), .err(err), .state_o(state_o)
  );
  always #5 clk = ~clk;
  assign outs = {cmd_ready, wld_ready, w_wr_en, w_addr_h, w_addr_i, w_data, nn_start, frame_done, run_done, err, state_o};
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic wr, input logic [0:0] h, input logic [1:0] i, input logic [15:0] d, input logic fd, input logic rd);
    exp_q.push_back('{wr, h, i, d, fd, rd});
  endtask
  task automatic cmd(input logic [1:0] op, input logic [7:0] fr);
    logic hs = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_frames = fr;
    for (int n = 0; n < 20 && !hs; n++) begin
      hs = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(hs), 32'(1));
  endtask
  task automatic load(input int n, input logic [15:0] base, input logic gap);
    int k = 0;
    while (k < n) begin
      if (gap && wld_valid) begin
        wld_valid = 1'b0;
        wld_data = 16'hdead;
      end else begin
        wld_valid = 1'b1;
        wld_data = 16'(base + 16'(k));
        push(1'b1, 1'(k / NI), 2'(k % NI), 16'(base + 16'(k)), 1'b0, k == NI * NH - 1);
        k++;
      end
      tick();
    end
    wld_valid = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (w_wr_en || frame_done || run_done) begin
      act = '{w_wr_en, w_wr_en ? w_addr_h : 1'b0, w_wr_en ? w_addr_i : 2'b0, w_wr_en ? w_data : 16'h0, frame_done, run_done};
      if (exp_q.size() == 0) chk("unexpected_event", 32'(act), 32'(0));
      else chk("event", 32'(act), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic held, started;
    int n;
    repeat (3) tick();
    chk("reset_outputs", 32'(outs), 32'(0));
    rst = 1'b0;
    tick();
    chk("cmd_ready_after_rst", 32'({cmd_ready, state_o}), 32'({1'b1, 3'd0}));
    cmd(2'd0, 8'd0);
    chk("load_entered", 32'({state_o, wld_ready}), 32'({3'd1, 1'b1}));
    load(8, 16'h0001, 1'b0);
    chk("load_done", 32'({wld_ready, state_o, cmd_ready}), 32'({1'b0, 3'd0, 1'b1}));
    cmd(2'd0, 8'd0);
    load(8, 16'h0001, 1'b1);
    chk("load_gap_done", 32'({wld_ready, state_o, cmd_ready}), 32'({1'b0, 3'd0, 1'b1}));
    cmd(2'd1, 8'd2);
    for (int f = 0; f < 2; f++) begin
      n = 0;
      while (!nn_start && n < 10) begin
        tick();
        n++;
      end
      chk("nn_start_seen", 32'({nn_start, state_o}), 32'({1'b1, 3'd2}));
      held = 1'b1;
      repeat (5) begin
        tick();
        held &= nn_start;
      end
      nn_busy = 1'b1;
      tick();
      chk("start_held_until_busy", 32'(held), 32'(1));
      chk("start_drop", 32'({nn_start, state_o}), 32'({1'b0, 3'd3}));
      tick();
      nn_busy = 1'b0;
      nn_out_valid = 1'b1;
      tick();
      nn_out_valid = 1'b0;
      tick();
      push(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, f == 1);
      nn_out_valid = 1'b1;
      tick();
      nn_out_valid = 1'b0;
      chk("frame_next_state", 32'(state_o), f == 1 ? 32'(0) : 32'(2));
    end
    chk("run_idle", 32'({cmd_ready, nn_start}), 32'({1'b1, 1'b0}));
    push(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
    cmd(2'd1, 8'd0);
    started = nn_start;
    repeat (3) begin
      tick();
      started |= nn_start;
    end
    chk("zero_frames_no_start", 32'({started, state_o}), 32'({1'b0, 3'd0}));
    chk("err_clean", 32'(err), 32'(0));
    cmd(2'd3, 8'd0);
    chk("err_illegal", 32'({err, state_o, cmd_ready}), 32'({1'b1, 3'd0, 1'b1}));
    nn_out_valid = 1'b1;
    tick();
    nn_out_valid = 1'b0;
    chk("err_outvalid", 32'({err, cmd_ready}), 32'({1'b1, 1'b1}));
    wld_valid = 1'b1;
    wld_data = 16'hbeef;
    tick();
    wld_valid = 1'b0;
    tick();
    chk("err_wld", 32'({err, cmd_ready, state_o}), 32'({1'b1, 1'b1, 3'd0}));
    cmd(2'd0, 8'd0);
    load(3, 16'h0021, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst", 32'(outs), 32'(0));
    rst = 1'b0;
    tick();
    cmd(2'd0, 8'd0);
    load(8, 16'h0031, 1'b0);
    chk("reload_done", 32'({wld_ready, state_o, cmd_ready, err}), 32'({1'b0, 3'd0, 1'b1, 1'b0}));
    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
